micro_sequencer: RTL
====================

// Module: micro_sequencer
// PURPOSE
//  Microprogram control unit for the cpu datapath (banco_registradores/ula/shifter/ram).
//  Holds a writable control store, owns the micro-PC, and drives the 28-bit mir each cycle.
//  Computes the next address from next-addr/JAM fields, the N/Z ALU flags and an opcode dispatch.
//  Start/stop/halt run control; loader port writes microcode while idle.
// PARAMETERS
//  MIR_W       28  datapath control word width (shift 2, ula 6, wr 2, addr 4, c 10, b 4)
//  ADDR_W      8   control store address width; depth = 2**ADDR_W
//  START_ADDR  0   micro-PC loaded on start
//  CNT_W       16  width of executed-microinstruction counter
//  CS_W = MIR_W+ADDR_W+4 (derived): word = {HALT,JMPC,JAMN,JAMZ,NEXT[ADDR_W-1:0],MIR[MIR_W-1:0]}
// PORTS
//  clock       in   1       rising-edge clock
//  reset       in   1       synchronous, active-high
//  start       in   1       pulse: begin execution at START_ADDR
//  stop        in   1       pulse: halt after the current microinstruction
//  flag_n      in   1       ALU result negative (combinational from ula, same cycle)
//  flag_z      in   1       ALU result zero (same cycle)
//  opcode      in   ADDR_W  dispatch value for JMPC (MBR low bits)
//  load_we     in   1       control store write strobe
//  load_addr   in   ADDR_W  control store write address
//  load_data   in   CS_W    control store write data
//  mir         out  MIR_W   microinstruction to datapath; all-zero = NOP
//  mpc         out  ADDR_W  current micro-PC
//  busy        out  1       1 in RUN
//  halted      out  1       1 in HALTED
//  load_err    out  1       1-cycle pulse: load_we while RUN (write dropped)
//  ucount      out  CNT_W   microinstructions issued since last start, saturating
// BEHAVIOUR
//  States: IDLE, RUN, HALTED. Reset -> IDLE, mpc=0, ucount=0, load_err=0; store NOT cleared.
//  mir = store[mpc].MIR combinationally in RUN; 0 in IDLE/HALTED (and in stalled step cycles).
//  IDLE/HALTED + start -> RUN next edge, mpc<=START_ADDR, ucount<=0. start in RUN ignored.
//  RUN, each edge: mpc <= next; ucount += 1 (saturates at all-ones).
//  next = NEXT; if JAMZ&flag_z or JAMN&flag_n: next[ADDR_W-1]=1; if JMPC: next = next | opcode.
//  Flags used are those produced by the mir presented in that same cycle.
//  HALT bit set in current word, or stop=1: word still issued this cycle (counted);
//   next edge -> HALTED, mpc holds that word's address. Both together: same result.
//  Halted word is issued exactly once; HALTED + start restarts at START_ADDR.
//  Loads: store[load_addr] <= load_data at edge when load_we and state != RUN.
//   load_we in RUN: no write, load_err=1 next cycle for one cycle.
//   load_we + start same edge (IDLE): write commits, RUN entered; new word visible next cycle.
//  mpc wraps modulo 2**ADDR_W; no error for NEXT pointing anywhere.
//  reset in RUN: IDLE next edge; mir=0 from that cycle on; datapath state untouched.
//  Control store write-first-cycle only; reads are asynchronous (distributed memory).
// CONFIGURATION
//  STEP_MODE_EN defined: extra ports step_mode (in,1) and step (in,1). In RUN with step_mode=1,
//   a word is issued (mir valid, mpc/ucount advance, halt/stop evaluated) only in cycles with
//   step=1; other cycles mir=0 and mpc/ucount hold. step_mode=0 -> free-running.
//  STEP_MODE_EN undefined: ports absent; RUN always issues one word per cycle.
// TESTING
//  Load words 0..2 (NEXT=1,2,0; word2 HALT), start -> mir = w0,w1,w2 on cycles 1-3; halted; ucount=3.
//  Word 5 JAMZ NEXT=0x10, flag_z=1 -> mpc=0x90; flag_z=0 -> mpc=0x10; JAMN analogously with flag_n.
//  Word 7 JMPC NEXT=0x00, opcode=0x2A -> mpc=0x2A; NEXT=0x80, opcode=0x05 -> mpc=0x85.
//  load_we during RUN -> store unchanged, load_err pulse 1 cycle; same load while IDLE -> written.
//  stop mid-run at mpc=0x03 -> word 3 issued, HALTED, mpc=0x03, mir=0; reset in RUN -> IDLE, mpc=0.
//  (STEP_MODE_EN) step_mode=1, step pulses every 3rd cycle -> mir nonzero only on step cycles, ucount=pulses.

Source files
------------

// File: rtl/micro_sequencer.sv
// Microprogram control unit: writable control store, micro-PC sequencing with JAM/JMPC branching,
// start/stop/halt run control. Optional single-step gating is enabled by defining STEP_MODE_EN.
module micro_sequencer #(
  parameter int MIR_W      = 28,
  parameter int ADDR_W     = 8,
  parameter int START_ADDR = 0,
  parameter int CNT_W      = 16,
  parameter int CS_W       = MIR_W + ADDR_W + 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              flag_n,
  input  logic              flag_z,
  input  logic [ADDR_W-1:0] opcode,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [CS_W-1:0]   load_data,
`ifdef STEP_MODE_EN
  input  logic              step_mode,
  input  logic              step,
`endif
  output logic [MIR_W-1:0]  mir,
  output logic [ADDR_W-1:0] mpc,
  output logic              busy,
  output logic              halted,
  output logic              load_err,
  output logic [CNT_W-1:0]  ucount
);

  localparam int DEPTH    = 2 ** ADDR_W;
  localparam int NEXT_LSB = MIR_W;
  localparam int JAMZ_BIT = MIR_W + ADDR_W;
  localparam int JAMN_BIT = MIR_W + ADDR_W + 1;
  localparam int JMPC_BIT = MIR_W + ADDR_W + 2;
  localparam int HALT_BIT = MIR_W + ADDR_W + 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t              state_r, state_n_s;
  logic [ADDR_W-1:0]   mpc_r, mpc_n_s;
  logic [CNT_W-1:0]    ucount_r, ucount_n_s;
  logic                load_err_r, load_err_n_s;

  logic [CS_W-1:0]     store_r [DEPTH];
  logic [CS_W-1:0]     word_s;
  logic                issue_s;
  logic                jam_s;
  logic [ADDR_W-1:0]   next_raw_s;
  logic [ADDR_W-1:0]   next_jam_s;
  logic [ADDR_W-1:0]   next_addr_s;

  assign word_s = store_r[mpc_r];

`ifdef STEP_MODE_EN
  assign issue_s = (state_r == RUN) && (!step_mode || step);
`else
  assign issue_s = (state_r == RUN);
`endif

  // Branch target: JAM forces the MSB, JMPC ORs in the dispatch opcode.
  assign jam_s       = (word_s[JAMZ_BIT] & flag_z) | (word_s[JAMN_BIT] & flag_n);
  assign next_raw_s  = word_s[NEXT_LSB +: ADDR_W];
  assign next_jam_s  = {next_raw_s[ADDR_W-1] | jam_s, next_raw_s[ADDR_W-2:0]};
  assign next_addr_s = word_s[JMPC_BIT] ? (next_jam_s | opcode) : next_jam_s;

  assign mir      = issue_s ? word_s[MIR_W-1:0] : '0;
  assign mpc      = mpc_r;
  assign busy     = (state_r == RUN);
  assign halted   = (state_r == HALTED);
  assign load_err = load_err_r;
  assign ucount   = ucount_r;

  // Control store write port; writes are refused while the sequencer is running.
  always_ff @(posedge clock) begin
    if (load_we && (state_r != RUN)) begin
      store_r[load_addr] <= load_data;
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= IDLE;
      mpc_r      <= '0;
      ucount_r   <= '0;
      load_err_r <= 1'b0;
    end else begin
      state_r    <= state_n_s;
      mpc_r      <= mpc_n_s;
      ucount_r   <= ucount_n_s;
      load_err_r <= load_err_n_s;
    end
  end

  // Next-state logic; a halting word keeps mpc on its own address.
  always_comb begin
    state_n_s    = state_r;
    mpc_n_s      = mpc_r;
    ucount_n_s   = ucount_r;
    load_err_n_s = load_we && (state_r == RUN);
    case (state_r)
      IDLE, HALTED: begin
        if (start) begin
          state_n_s  = RUN;
          mpc_n_s    = ADDR_W'(START_ADDR);
          ucount_n_s = '0;
        end else begin
          state_n_s  = state_r;
        end
      end
      RUN: begin
        if (issue_s) begin
          ucount_n_s = (ucount_r == {CNT_W{1'b1}}) ? ucount_r : (ucount_r + CNT_W'(1));
          if (word_s[HALT_BIT] || stop) begin
            state_n_s = HALTED;
          end else begin
            mpc_n_s   = next_addr_s;
          end
        end else begin
          mpc_n_s = mpc_r;
        end
      end
      default: begin
        state_n_s = IDLE;
        mpc_n_s   = '0;
      end
    endcase
  end

endmodule
